// File: rtl/reg_pair_push.sv
// reg_pair_push: pushes a 16-bit register pair onto the byte bus (high byte first) and returns SP-2.
// Optional macro REG_POP_EN adds the matching POP sequence (low byte first, SP+2, pair_out).
module reg_pair_push #(
    parameter int WIDTH      = 8,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
`ifdef REG_POP_EN
    input  logic                  pop,
`endif
    input  logic [2*WIDTH-1:0]    pair,
    input  logic [ADDR_WIDTH-1:0] sp_in,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0]      mem_wdata,
    output logic                  mem_wr,
    output logic                  mem_rd,
    input  logic [WIDTH-1:0]      mem_rdata,
    input  logic                  mem_ack,
    output logic [ADDR_WIDTH-1:0] sp_out,
    output logic                  sp_we,
    output logic                  busy,
`ifdef REG_POP_EN
    output logic [2*WIDTH-1:0]    pair_out,
`endif
    output logic                  done
);

`ifdef REG_POP_EN
    typedef enum logic [2:0] {
        IDLE,
        WR_HI,
        WR_LO,
        FIN,
        RD_LO,
        RD_HI
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE,
        WR_HI,
        WR_LO,
        FIN
    } state_t;
`endif

    state_t                  state;
    state_t                  next_state;
    logic [2*WIDTH-1:0]      pair_q;
    logic [ADDR_WIDTH-1:0]   sp_q;
    logic [ADDR_WIDTH-1:0]   sp_dec1;
    logic [ADDR_WIDTH-1:0]   sp_dec2;

    // SP arithmetic wraps naturally at the address width.
    assign sp_dec1 = sp_q - ADDR_WIDTH'(1);
    assign sp_dec2 = sp_q - ADDR_WIDTH'(2);

`ifdef REG_POP_EN
    logic                    pop_q;
    logic [ADDR_WIDTH-1:0]   sp_inc1;
    logic [ADDR_WIDTH-1:0]   sp_inc2;

    assign sp_inc1 = sp_q + ADDR_WIDTH'(1);
    assign sp_inc2 = sp_q + ADDR_WIDTH'(2);
`else
    logic                    unused_rdata;

    assign unused_rdata = ^mem_rdata;
`endif

    // Operands are captured once on an accepted start so later input changes cannot disturb the transfer.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= IDLE;
            pair_q <= '0;
            sp_q   <= '0;
`ifdef REG_POP_EN
            pop_q  <= 1'b0;
`endif
        end else begin
            state <= next_state;
            if (state == IDLE && start) begin
                pair_q <= pair;
                sp_q   <= sp_in;
`ifdef REG_POP_EN
                pop_q  <= pop;
`endif
            end
`ifdef REG_POP_EN
            if (state == RD_LO && mem_ack) begin
                pair_q[WIDTH-1:0] <= mem_rdata;
            end
            if (state == RD_HI && mem_ack) begin
                pair_q[2*WIDTH-1:WIDTH] <= mem_rdata;
            end
`endif
        end
    end

    always_comb begin
        next_state = state;
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_wr     = 1'b0;
        mem_rd     = 1'b0;
        sp_out     = '0;
        sp_we      = 1'b0;
        done       = 1'b0;
`ifdef REG_POP_EN
        pair_out   = '0;
`endif
        case (state)
            IDLE: begin
                if (start) begin
`ifdef REG_POP_EN
                    next_state = pop ? RD_LO : WR_HI;
`else
                    next_state = WR_HI;
`endif
                end
            end
            WR_HI: begin
                mem_addr  = sp_dec1;
                mem_wdata = pair_q[2*WIDTH-1:WIDTH];
                mem_wr    = 1'b1;
                if (mem_ack) begin
                    next_state = WR_LO;
                end
            end
            WR_LO: begin
                mem_addr  = sp_dec2;
                mem_wdata = pair_q[WIDTH-1:0];
                mem_wr    = 1'b1;
                if (mem_ack) begin
                    next_state = FIN;
                end
            end
            FIN: begin
                sp_we      = 1'b1;
                done       = 1'b1;
                next_state = IDLE;
`ifdef REG_POP_EN
                sp_out     = pop_q ? sp_inc2 : sp_dec2;
                pair_out   = pair_q;
`else
                sp_out     = sp_dec2;
`endif
            end
`ifdef REG_POP_EN
            RD_LO: begin
                mem_addr = sp_q;
                mem_rd   = 1'b1;
                if (mem_ack) begin
                    next_state = RD_HI;
                end
            end
            RD_HI: begin
                mem_addr = sp_inc1;
                mem_rd   = 1'b1;
                if (mem_ack) begin
                    next_state = FIN;
                end
            end
`endif
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_reg_pair_push.sv
// Directed bench for reg_pair_push: expected bus writes and SP results are queued
// when a push is started and consumed as the bus and SP write-back are observed.
module tb_reg_pair_push;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        pop;
    logic [15:0] pair;
    logic [15:0] sp_in;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_wr;
    logic        mem_rd;
    logic [7:0]  mem_rdata;
    logic        ack;
    logic [15:0] sp_out;
    logic        sp_we;
    logic        busy;
    logic        done;
    logic [15:0] pair_out;

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
    } wr_t;

    wr_t         exp_wr[$];
    logic [15:0] exp_sp[$];
    int          checks      = 0;
    int          errors      = 0;
    int          write_count = 0;
    int          done_count  = 0;
    logic        prev_wait   = 1'b0;
    int          wc0;
    int          dc0;

    always #5 clk = ~clk;

    reg_pair_push #(
        .WIDTH(8),
        .ADDR_WIDTH(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
`ifdef REG_POP_EN
        .pop(pop),
        .pair_out(pair_out),
`endif
        .pair(pair),
        .sp_in(sp_in),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_wr(mem_wr),
        .mem_rd(mem_rd),
        .mem_rdata(mem_rdata),
        .mem_ack(ack),
        .sp_out(sp_out),
        .sp_we(sp_we),
        .busy(busy),
        .done(done)
    );

`ifdef REG_POP_EN
    always_comb begin
        case (mem_addr)
            16'hC000: mem_rdata = 8'h34;
            16'hC001: mem_rdata = 8'h12;
            default:  mem_rdata = 8'h00;
        endcase
    end
`else
    assign mem_rdata = 8'h00;
    assign pair_out  = 16'h0000;
`endif

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic expectPush(input logic [15:0] p, input logic [15:0] sp);
        exp_wr.push_back({sp - 16'd1, p[15:8]});
        exp_wr.push_back({sp - 16'd2, p[7:0]});
        exp_sp.push_back(sp - 16'd2);
    endtask

    // Scoreboard: every write cycle must match the head entry; the entry retires only on ack.
    task automatic observe();
        if (prev_wait) begin
            checkOutput("wr_held", mem_wr, 1'b1);
        end
        if (mem_wr) begin
            checkOutput("wr_expected", exp_wr.size() != 0, 1'b1);
            if (exp_wr.size() != 0) begin
                checkOutput("wr_addr", mem_addr, exp_wr[0].addr);
                checkOutput("wr_data", mem_wdata, exp_wr[0].data);
                if (ack) begin
                    void'(exp_wr.pop_front());
                    write_count++;
                end
            end
        end
        if (sp_we || done) begin
            checkOutput("done_pulse", done, 1'b1);
            checkOutput("sp_we_pulse", sp_we, 1'b1);
            checkOutput("sp_expected", exp_sp.size() != 0, 1'b1);
            if (exp_sp.size() != 0) begin
                checkOutput("sp_out", sp_out, exp_sp.pop_front());
            end
            done_count++;
        end
        prev_wait = mem_wr && !ack && rst;
    endtask

    task automatic applyStimulus(input logic s, input logic a, input logic r);
        @(posedge clk);
        #1;
        start = s;
        ack   = a;
        rst   = r;
        @(negedge clk);
        observe();
    endtask

    initial begin
        logic [15:0] tbl_pair [3];
        logic [15:0] tbl_sp   [3];

        rst   = 1'b0;
        start = 1'b0;
        ack   = 1'b0;
        pop   = 1'b0;
        pair  = 16'h0000;
        sp_in = 16'h0000;

        applyStimulus(0, 0, 0);
        applyStimulus(0, 0, 0);
        checkOutput("rst_mem_addr", mem_addr, 16'h0000);
        checkOutput("rst_mem_wdata", mem_wdata, 8'h00);
        checkOutput("rst_mem_wr", mem_wr, 1'b0);
        checkOutput("rst_mem_rd", mem_rd, 1'b0);
        checkOutput("rst_sp_out", sp_out, 16'h0000);
        checkOutput("rst_sp_we", sp_we, 1'b0);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_done", done, 1'b0);

        // T1: back-to-back acks
        $display("[TB] T1 zero-wait push");
        pair  = 16'hBEEF;
        sp_in = 16'hFFFE;
        expectPush(pair, sp_in);
        applyStimulus(1, 1, 1);
        checkOutput("t1_idle_busy", busy, 1'b0);
        applyStimulus(0, 1, 1);
        pair  = 16'h5A5A;
        sp_in = 16'h1234;
        checkOutput("t1_hi_addr", mem_addr, 16'hFFFD);
        checkOutput("t1_hi_data", mem_wdata, 8'hBE);
        checkOutput("t1_busy", busy, 1'b1);
        applyStimulus(0, 1, 1);
        checkOutput("t1_lo_addr", mem_addr, 16'hFFFC);
        checkOutput("t1_lo_data", mem_wdata, 8'hEF);
        applyStimulus(0, 1, 1);
        checkOutput("t1_done_n3", done, 1'b1);
        checkOutput("t1_sp_we_n3", sp_we, 1'b1);
        checkOutput("t1_sp_out", sp_out, 16'hFFFC);
        checkOutput("t1_fin_wr", mem_wr, 1'b0);
        applyStimulus(0, 1, 1);
        checkOutput("t1_idle_done", done, 1'b0);
        checkOutput("t1_idle_busy_end", busy, 1'b0);

        // T2: three wait cycles per write
        $display("[TB] T2 wait-state push");
        pair  = 16'hBEEF;
        sp_in = 16'hFFFE;
        expectPush(pair, sp_in);
        applyStimulus(1, 0, 1);
        for (int c = 1; c <= 8; c++) begin
            applyStimulus(0, (c % 4) == 0, 1);
            checkOutput("t2_wr", mem_wr, 1'b1);
            checkOutput("t2_no_done", done, 1'b0);
        end
        applyStimulus(0, 1, 1);
        checkOutput("t2_done_n9", done, 1'b1);
        applyStimulus(0, 1, 1);
        checkOutput("t2_idle_busy", busy, 1'b0);

        // T3: SP wrap-around and a mid-range value
        $display("[TB] T3 SP wrap");
        tbl_pair[0] = 16'h1234; tbl_sp[0] = 16'h0001;
        tbl_pair[1] = 16'hABCD; tbl_sp[1] = 16'h0000;
        tbl_pair[2] = 16'h00FF; tbl_sp[2] = 16'h8000;
        for (int i = 0; i < 3; i++) begin
            pair  = tbl_pair[i];
            sp_in = tbl_sp[i];
            expectPush(pair, sp_in);
            applyStimulus(1, 1, 1);
            repeat (3) applyStimulus(0, 1, 1);
            checkOutput("t3_done", done, 1'b1);
            applyStimulus(0, 1, 1);
        end

        // T4: start while busy is dropped, not queued
        $display("[TB] T4 start ignored while busy");
        wc0   = write_count;
        dc0   = done_count;
        pair  = 16'hA55A;
        sp_in = 16'h8000;
        expectPush(pair, sp_in);
        applyStimulus(1, 1, 1);
        applyStimulus(0, 1, 1);
        pair  = 16'h1111;
        sp_in = 16'h2222;
        applyStimulus(1, 1, 1);
        applyStimulus(1, 1, 1);
        checkOutput("t4_done", done, 1'b1);
        applyStimulus(0, 1, 1);
        checkOutput("t4_not_busy", busy, 1'b0);
        applyStimulus(0, 1, 1);
        checkOutput("t4_writes", write_count - wc0, 2);
        checkOutput("t4_dones", done_count - dc0, 1);

        // T5: reset while waiting on the high-byte write
        $display("[TB] T5 reset mid-operation");
        pair  = 16'h7777;
        sp_in = 16'h4000;
        exp_wr.push_back({16'h3FFF, 8'h77});
        dc0 = done_count;
        applyStimulus(1, 0, 1);
        applyStimulus(0, 0, 1);
        applyStimulus(0, 0, 0);
        applyStimulus(0, 1, 1);
        exp_wr.delete();
        checkOutput("t5_mem_addr", mem_addr, 16'h0000);
        checkOutput("t5_mem_wdata", mem_wdata, 8'h00);
        checkOutput("t5_mem_wr", mem_wr, 1'b0);
        checkOutput("t5_sp_out", sp_out, 16'h0000);
        checkOutput("t5_busy", busy, 1'b0);
        repeat (4) applyStimulus(0, 1, 1);
        checkOutput("t5_no_done", done_count - dc0, 0);

`ifdef REG_POP_EN
        // T6: POP from memory
        $display("[TB] T6 pop");
        pop   = 1'b1;
        sp_in = 16'hC000;
        exp_sp.push_back(16'hC002);
        applyStimulus(1, 1, 1);
        pop = 1'b0;
        applyStimulus(0, 1, 1);
        checkOutput("t6_rd_lo", mem_rd, 1'b1);
        checkOutput("t6_lo_addr", mem_addr, 16'hC000);
        applyStimulus(0, 1, 1);
        checkOutput("t6_hi_addr", mem_addr, 16'hC001);
        applyStimulus(0, 1, 1);
        checkOutput("t6_pair_out", pair_out, 16'h1234);
        applyStimulus(0, 1, 1);
`endif

        checkOutput("sb_writes_drained", exp_wr.size(), 0);
        checkOutput("sb_sp_drained", exp_sp.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
